// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time game.
//   state_t  : sequencer states, encoded as they appear on the state port
//   BCD_W    : width of the three-digit BCD result / high score
//   NO_SCORE : high-score value meaning "nothing recorded yet"
//   beats_best() : true when a result should replace the stored best
package reaction_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_COUNT = 2'd2,
        ST_SHOW  = 2'd3
    } state_t;

    localparam int BCD_W = 12;
    localparam logic [BCD_W-1:0] NO_SCORE = '0;

    // A zero result is never a valid score; an empty slot accepts anything else.
    // BCD digits compare correctly as plain unsigned binary.
    function automatic logic beats_best(input logic [BCD_W-1:0] result,
                                        input logic [BCD_W-1:0] best);
        return (result != NO_SCORE) && ((best == NO_SCORE) || (result < best));
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a debounced button level.
//   clk   : sampling clock
//   rst   : asynchronous, active-high reset
//   level : button level
//   pulse : one-cycle-wide (combinational) pulse on a low-to-high transition
// After reset the detector is disarmed until level has been seen low on a
// clock edge, so a button held through reset does not count as a press.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q_reg;
    logic armed_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q_reg <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            level_q_reg <= level;
            if (!level)
                armed_reg <= 1'b1;
        end
    end

    assign pulse = level & ~level_q_reg & armed_reg;

endmodule

// File: rtl/reaction_sequencer.sv
// Reaction-time game sequencer.
//   clk1hz      : 1 Hz game clock
//   resetButton : asynchronous, active-high reset
//   run         : debounced run button level
//   rand_delay  : random wait length in seconds
//   result_bcd  : hundredths counter value (3 BCD digits)
//   state       : 0 IDLE, 1 WAIT, 2 COUNT, 3 SHOW
//   count_clr   : clears the BCD counter chain (IDLE/WAIT)
//   count_en    : enables the BCD counter chain (COUNT)
//   ready_time  : latched wait length of this round
//   timer       : seconds elapsed in WAIT or COUNT
//   high_score  : best (lowest) result so far, 0 = none
//   new_high / false_start / timed_out : outcome flags of the last round
module reaction_sequencer
    import reaction_pkg::*;
#(
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 9
) (
    input  logic              clk1hz,
    input  logic              resetButton,
    input  logic              run,
    input  logic [3:0]        rand_delay,
    input  logic [BCD_W-1:0]  result_bcd,
    output logic [1:0]        state,
    output logic              count_clr,
    output logic              count_en,
    output logic [3:0]        ready_time,
    output logic [3:0]        timer,
    output logic [BCD_W-1:0]  high_score,
    output logic              new_high,
    output logic              false_start,
    output logic              timed_out
);

    localparam logic [3:0] MIN_WAIT_4 = 4'(MIN_WAIT);
    localparam logic [3:0] TIMEOUT_M1 = 4'(TIMEOUT - 1);

    logic press;

    rise_detect u_rise_detect (
        .clk   (clk1hz),
        .rst   (resetButton),
        .level (run),
        .pulse (press)
    );

    state_t             state_reg, state_next;
    logic [3:0]         timer_reg, timer_next;
    logic [3:0]         ready_time_reg, ready_time_next;
    logic [BCD_W-1:0]   high_score_reg, high_score_next;
    logic               new_high_reg, new_high_next;
    logic               false_start_reg, false_start_next;
    logic               timed_out_reg, timed_out_next;
    // Set on entry to SHOW so the score comparison happens on exactly one edge.
    logic               score_pending_reg, score_pending_next;

    always_ff @(posedge clk1hz or posedge resetButton) begin
        if (resetButton) begin
            state_reg         <= ST_IDLE;
            timer_reg         <= '0;
            ready_time_reg    <= '0;
            high_score_reg    <= NO_SCORE;
            new_high_reg      <= 1'b0;
            false_start_reg   <= 1'b0;
            timed_out_reg     <= 1'b0;
            score_pending_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            timer_reg         <= timer_next;
            ready_time_reg    <= ready_time_next;
            high_score_reg    <= high_score_next;
            new_high_reg      <= new_high_next;
            false_start_reg   <= false_start_next;
            timed_out_reg     <= timed_out_next;
            score_pending_reg <= score_pending_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        timer_next         = timer_reg;
        ready_time_next    = ready_time_reg;
        high_score_next    = high_score_reg;
        new_high_next      = new_high_reg;
        false_start_next   = false_start_reg;
        timed_out_next     = timed_out_reg;
        score_pending_next = score_pending_reg;

        case (state_reg)
            ST_IDLE: begin
                if (press) begin
                    state_next       = ST_WAIT;
                    ready_time_next  = (rand_delay < MIN_WAIT_4) ? MIN_WAIT_4 : rand_delay;
                    timer_next       = '0;
                    false_start_next = 1'b0;
                    new_high_next    = 1'b0;
                    timed_out_next   = 1'b0;
                end
            end
            ST_WAIT: begin
                // A press wins even on the edge where the wait would expire.
                if (press) begin
                    state_next       = ST_IDLE;
                    false_start_next = 1'b1;
                    timer_next       = '0;
                end else if (timer_reg == ready_time_reg - 4'd1) begin
                    state_next = ST_COUNT;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 4'd1;
                end
            end
            ST_COUNT: begin
                if (press) begin
                    state_next         = ST_SHOW;
                    timer_next         = '0;
                    score_pending_next = 1'b1;
                end else if (timer_reg == TIMEOUT_M1) begin
                    state_next         = ST_SHOW;
                    timed_out_next     = 1'b1;
                    timer_next         = '0;
                    score_pending_next = 1'b1;
                end else begin
                    timer_next = timer_reg + 4'd1;
                end
            end
            ST_SHOW: begin
                if (score_pending_reg) begin
                    score_pending_next = 1'b0;
                    if (!timed_out_reg && beats_best(result_bcd, high_score_reg)) begin
                        high_score_next = result_bcd;
                        new_high_next   = 1'b1;
                    end
                end
                if (press)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign state       = state_reg;
    assign count_clr   = (state_reg == ST_IDLE) || (state_reg == ST_WAIT);
    assign count_en    = (state_reg == ST_COUNT);
    assign ready_time  = ready_time_reg;
    assign timer       = timer_reg;
    assign high_score  = high_score_reg;
    assign new_high    = new_high_reg;
    assign false_start = false_start_reg;
    assign timed_out   = timed_out_reg;

endmodule

// File: tb/tb_reaction_sequencer.sv
// Self-checking bench for reaction_sequencer: directed game rounds followed by
// random button activity, compared against a reference model of the game.
module tb_reaction_sequencer;

    localparam int MIN_WAIT = 1;
    localparam int TIMEOUT  = 9;

    logic        clk1hz = 1'b0;
    logic        resetButton;
    logic        run;
    logic [3:0]  rand_delay;
    logic [11:0] result_bcd;
    logic [1:0]  state;
    logic        count_clr;
    logic        count_en;
    logic [3:0]  ready_time;
    logic [3:0]  timer;
    logic [11:0] high_score;
    logic        new_high;
    logic        false_start;
    logic        timed_out;

    reaction_sequencer #(.MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk1hz      (clk1hz),
        .resetButton (resetButton),
        .run         (run),
        .rand_delay  (rand_delay),
        .result_bcd  (result_bcd),
        .state       (state),
        .count_clr   (count_clr),
        .count_en    (count_en),
        .ready_time  (ready_time),
        .timer       (timer),
        .high_score  (high_score),
        .new_high    (new_high),
        .false_start (false_start),
        .timed_out   (timed_out)
    );

    always #5 clk1hz = ~clk1hz;

    typedef struct {
        logic [1:0]  st;
        logic        clr;
        logic        en;
        logic [3:0]  rt;
        logic [3:0]  tmr;
        logic [11:0] hs;
        logic        nh;
        logic        fs;
        logic        to;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    // Reference model: game phase (0 idle, 1 waiting, 2 counting, 3 showing)
    // with plain integer bookkeeping.
    int m_phase, m_tmr, m_rt, m_hs, m_nh, m_fs, m_to;
    int m_runq, m_armed, m_show_edges;

    task automatic model_reset();
        m_phase = 0; m_tmr = 0; m_rt = 0; m_hs = 0;
        m_nh = 0; m_fs = 0; m_to = 0;
        m_runq = 0; m_armed = 0; m_show_edges = 0;
    endtask

    task automatic model_edge(input logic r, input int rd, input int res);
        bit pressed;
        pressed = r && (m_runq == 0) && (m_armed != 0);
        m_runq = r;
        if (!r) m_armed = 1;
        case (m_phase)
            0: if (pressed) begin
                m_phase = 1;
                m_rt = (rd < MIN_WAIT) ? MIN_WAIT : rd;
                m_tmr = 0; m_fs = 0; m_nh = 0; m_to = 0;
            end
            1: if (pressed) begin
                m_phase = 0; m_fs = 1; m_tmr = 0;
            end else if (m_tmr + 1 == m_rt) begin
                m_phase = 2; m_tmr = 0;
            end else m_tmr++;
            2: if (pressed || m_tmr + 1 == TIMEOUT) begin
                if (!pressed) m_to = 1;
                m_phase = 3; m_tmr = 0; m_show_edges = 0;
            end else m_tmr++;
            default: begin
                if (m_show_edges == 0 && m_to == 0 && res != 0 && (m_hs == 0 || res < m_hs)) begin
                    m_hs = res; m_nh = 1;
                end
                m_show_edges++;
                if (pressed) m_phase = 0;
            end
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.st  = 2'(m_phase);
        e.clr = (m_phase == 0) || (m_phase == 1);
        e.en  = (m_phase == 2);
        e.rt  = 4'(m_rt);
        e.tmr = 4'(m_tmr);
        e.hs  = 12'(m_hs);
        e.nh  = (m_nh != 0);
        e.fs  = (m_fs != 0);
        e.to  = (m_to != 0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, predict the next rising edge.
    task automatic step(input logic rst, input logic r, input logic [3:0] rd, input logic [11:0] res);
        @(negedge clk1hz);
        resetButton = rst;
        run         = r;
        rand_delay  = rd;
        result_bcd  = res;
        if (rst) model_reset();
        else model_edge(r, int'(rd), int'(res));
        q.push_back(model_out());
    endtask

    // Press on one edge, release on the next.
    task automatic press_release(input logic [3:0] rd, input logic [11:0] res);
        step(1'b0, 1'b1, rd, res);
        step(1'b0, 1'b0, rd, res);
    endtask

    // Complete round: wait the full delay, react after two COUNT edges, leave SHOW.
    task automatic full_round(input logic [3:0] rd, input logic [11:0] res);
        int rt;
        rt = (int'(rd) < MIN_WAIT) ? MIN_WAIT : int'(rd);
        press_release(rd, res);
        for (int i = 0; i < rt - 1; i++) step(1'b0, 1'b0, rd, res);
        step(1'b0, 1'b0, rd, res);
        step(1'b0, 1'b1, rd, res);
        step(1'b0, 1'b0, rd, res);
        press_release(rd, res);
    endtask

    task automatic settle_check(input string nm, input logic [11:0] hs_req, input logic nh_req);
        @(posedge clk1hz);
        #2;
        chk({nm, "_high_score"}, high_score, hs_req);
        chk({nm, "_new_high"}, 12'(new_high), 12'(nh_req));
    endtask

    // Monitor: compare every predicted response just after the rising edge.
    logic [1:0] prev_state = 2'd0;
    always @(posedge clk1hz) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("state",       12'(state),       12'(e.st));
            chk("count_clr",   12'(count_clr),   12'(e.clr));
            chk("count_en",    12'(count_en),    12'(e.en));
            chk("ready_time",  12'(ready_time),  12'(e.rt));
            chk("timer",       12'(timer),       12'(e.tmr));
            chk("high_score",  high_score,       e.hs);
            chk("new_high",    12'(new_high),    12'(e.nh));
            chk("false_start", 12'(false_start), 12'(e.fs));
            chk("timed_out",   12'(timed_out),   12'(e.to));
            if (state !== prev_state)
                $display("t=%0t state %0d -> %0d rt=%0d hs=%03h nh=%0b fs=%0b to=%0b",
                         $time, prev_state, state, ready_time, high_score,
                         new_high, false_start, timed_out);
            prev_state = state;
        end
    end

    initial begin
        logic [11:0] res;
        resetButton = 1'b1;
        run         = 1'b1;
        rand_delay  = 4'd0;
        result_bcd  = 12'h000;
        model_reset();
        #1;
        chk("reset_state", 12'(state), 12'd0);
        chk("reset_clr",   12'(count_clr), 12'd1);
        chk("reset_hs",    high_score, 12'h000);

        // Run held high through reset release must not count as a press.
        step(1'b1, 1'b1, 4'd3, 12'h000);
        step(1'b1, 1'b1, 4'd3, 12'h000);
        step(1'b0, 1'b1, 4'd3, 12'h000);
        step(1'b0, 1'b1, 4'd3, 12'h000);
        step(1'b0, 1'b0, 4'd3, 12'h000);

        // First score, worse score, better score.
        full_round(4'd3, 12'h245);
        settle_check("round1", 12'h245, 1'b1);
        full_round(4'd2, 12'h310);
        settle_check("round2", 12'h245, 1'b0);
        full_round(4'd4, 12'h198);
        settle_check("round3", 12'h198, 1'b1);

        // False start two edges into a five-second wait.
        press_release(4'd5, 12'h111);
        step(1'b0, 1'b0, 4'd5, 12'h111);
        step(1'b0, 1'b1, 4'd5, 12'h111);
        step(1'b0, 1'b0, 4'd5, 12'h111);

        // Minimum wait, then let COUNT time out.
        press_release(4'd0, 12'h050);
        for (int i = 0; i < TIMEOUT + 2; i++) step(1'b0, 1'b0, 4'd0, 12'h050);
        settle_check("timeout", 12'h198, 1'b0);
        press_release(4'd0, 12'h050);

        // Press on the exact edge the wait expires.
        press_release(4'd2, 12'h077);
        step(1'b0, 1'b1, 4'd2, 12'h077);
        step(1'b0, 1'b0, 4'd2, 12'h077);

        // Button held across several edges: only one transition.
        step(1'b0, 1'b1, 4'd6, 12'h000);
        step(1'b0, 1'b1, 4'd6, 12'h000);
        step(1'b0, 1'b1, 4'd6, 12'h000);
        step(1'b0, 1'b1, 4'd6, 12'h000);
        step(1'b0, 1'b0, 4'd6, 12'h000);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 4'd6, 12'h000);
        press_release(4'd0, 12'h000);

        // Reach COUNT, then assert reset between clock edges.
        press_release(4'd2, 12'h123);
        step(1'b0, 1'b0, 4'd2, 12'h123);
        step(1'b0, 1'b0, 4'd2, 12'h123);
        @(posedge clk1hz);
        #2;
        chk("pre_reset_count_en", 12'(count_en), 12'd1);
        resetButton = 1'b1;
        #1;
        chk("async_reset_state", 12'(state), 12'd0);
        chk("async_reset_hs",    high_score, 12'h000);
        chk("async_reset_en",    12'(count_en), 12'd0);
        chk("async_reset_timer", 12'(timer), 12'd0);
        model_reset();
        step(1'b1, 1'b0, 4'd0, 12'h000);
        step(1'b0, 1'b0, 4'd0, 12'h000);

        // Random play.
        for (int i = 0; i < 600; i++) begin
            res = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 7) == 0) res = 12'h000;
            step(1'b0, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 5)), res);
        end

        @(posedge clk1hz);
        #2;
        chk("queue_drained", 12'(q.size()), 12'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
